// File: rtl/fft_output_serializer.sv
// Ping-pong frame buffer that serializes FFT butterfly pairs into one complex sample per cycle.
// Define FFT_BITREV_OUT_EN to read each frame in bit-reversed address order.
module fft_output_serializer #(
    parameter int N     = 1024,
    parameter int DW    = 32,
    localparam int LOG2N = $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid_in,
    input  logic [DW-1:0]    i_data_a_real,
    input  logic [DW-1:0]    i_data_a_imag,
    input  logic [DW-1:0]    i_data_b_real,
    input  logic [DW-1:0]    i_data_b_imag,
    input  logic             i_ready,
    output logic             o_valid_out,
    output logic [DW-1:0]    o_data_real,
    output logic [DW-1:0]    o_data_imag,
    output logic [LOG2N-1:0] o_index,
    output logic             o_last,
    output logic             o_overflow
);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    state_t              state;
    logic [2*DW-1:0]     mem [2*N];
    logic [2*DW-1:0]     ram_q;
    logic [LOG2N-2:0]    wr_cnt;
    logic                wr_bank;
    logic                rd_bank;
    logic [1:0]          full;
    logic [LOG2N-1:0]    rd_cnt;
    logic [LOG2N-1:0]    rd_next;
    logic [LOG2N-1:0]    rd_next2;
    logic                rd_en;
    logic [LOG2N-1:0]    rd_addr;
    logic                accept;
    logic                fill;
    logic                drain;

    function automatic logic [LOG2N-1:0] map_addr(input logic [LOG2N-1:0] c);
        logic [LOG2N-1:0] r;
`ifdef FFT_BITREV_OUT_EN
        for (int i = 0; i < LOG2N; i++) r[i] = c[LOG2N-1-i];
`else
        r = c;
`endif
        return r;
    endfunction

    assign accept   = i_valid_in & ~full[wr_bank];
    assign fill     = accept & (wr_cnt == '1);
    assign drain    = (state == STREAM) & o_valid_out & i_ready & (rd_cnt == LAST_IDX);
    assign rd_next  = rd_cnt + LOG2N'(1);
    assign rd_next2 = rd_cnt + LOG2N'(2);
    assign o_index  = rd_cnt;

    // The RAM output register always holds the sample after the one being presented.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rd_en   = 1'b0;
        rd_addr = map_addr(rd_cnt);
        case (state)
            PRIME: rd_en = 1'b1;
            STREAM: begin
                if (!o_valid_out) begin
                    rd_en   = 1'b1;
                    rd_addr = map_addr(rd_next);
                end else if (i_ready) begin
                    rd_en   = 1'b1;
                    rd_addr = map_addr(rd_next2);
                end
            end
            default: ;
        endcase
    end

    // NOTE: the buffer RAM has no reset; its contents are meaningless until a frame is written.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[{wr_bank, wr_cnt, 1'b0}] <= {i_data_a_real, i_data_a_imag};
            mem[{wr_bank, wr_cnt, 1'b1}] <= {i_data_b_real, i_data_b_imag};
        end
        if (rd_en) ram_q <= mem[{rd_bank, rd_addr}];
    end

    // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_valid_in) begin
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (fill) wr_bank <= ~wr_bank;
            end else begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Fill and drain always target different banks, so both may apply in one cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            full <= 2'b00;
        end else begin
            full <= (full | (fill ? (2'b01 << wr_bank) : 2'b00))
                  & ~(drain ? (2'b01 << rd_bank) : 2'b00);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_cnt      <= '0;
            o_valid_out <= 1'b0;
            o_data_real <= '0;
            o_data_imag <= '0;
            o_last      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) state <= PRIME;
                end
                PRIME: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (!o_valid_out) begin
                        o_valid_out                <= 1'b1;
                        {o_data_real, o_data_imag} <= ram_q;
                        o_last                     <= (rd_cnt == LAST_IDX);
                    end else if (i_ready) begin
                        rd_cnt <= rd_next;
                        if (rd_cnt == LAST_IDX) begin
                            o_valid_out <= 1'b0;
                            o_last      <= 1'b0;
                            rd_bank     <= ~rd_bank;
                            state       <= full[~rd_bank] ? PRIME : IDLE;
                        end else begin
                            {o_data_real, o_data_imag} <= ram_q;
                            o_last                     <= (rd_next == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed self-checking bench for fft_output_serializer: reset, latency, order, backpressure,
// overflow and mid-stream reset. Expected order follows FFT_BITREV_OUT_EN when it is defined.
module tb_fft_output_serializer;

    localparam int N     = 1024;
    localparam int DW    = 32;
    localparam int LOG2N = $clog2(N);

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_valid_in;
    logic [DW-1:0]    i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag;
    logic             i_ready;
    logic             o_valid_out;
    logic [DW-1:0]    o_data_real, o_data_imag;
    logic [LOG2N-1:0] o_index;
    logic             o_last;
    logic             o_overflow;

    int errors = 0;
    int checks = 0;

    fft_output_serializer #(.N(N), .DW(DW)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid_in   (i_valid_in),
        .i_data_a_real(i_data_a_real),
        .i_data_a_imag(i_data_a_imag),
        .i_data_b_real(i_data_b_real),
        .i_data_b_imag(i_data_b_imag),
        .i_ready      (i_ready),
        .o_valid_out  (o_valid_out),
        .o_data_real  (o_data_real),
        .o_data_imag  (o_data_imag),
        .o_index      (o_index),
        .o_last       (o_last),
        .o_overflow   (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Stored sample value: frame number in the upper half, frame position in the lower half.
    function automatic logic [DW-1:0] val(input int f, input int p);
        return DW'(f * 65536 + p);
    endfunction

    function automatic int addr_of(input int i);
        int r;
`ifdef FFT_BITREV_OUT_EN
        r = 0;
        for (int b = 0; b < LOG2N; b++) if (((i >> b) & 1) != 0) r |= 1 << (LOG2N - 1 - b);
`else
        r = i;
`endif
        return r;
    endfunction

    task automatic send_pairs(input int f, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            i_valid_in    = 1'b1;
            i_data_a_real = val(f, 2 * k);
            i_data_a_imag = 0 - val(f, 2 * k);
            i_data_b_real = val(f, 2 * k + 1);
            i_data_b_imag = 0 - val(f, 2 * k + 1);
            tick();
        end
        i_valid_in = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_valid_out && n < 200) begin
            tick();
            n++;
        end
        check(tag, 64'(o_valid_out), 64'd1);
    endtask

    task automatic stream_frame(input int f, input bit bp);
        logic [DW-1:0] e;
        wait_valid($sformatf("f%0d start", f));
        for (int i = 0; i < N; i++) begin
            e = val(f, addr_of(i));
            check($sformatf("f%0d i%0d valid", f, i), 64'(o_valid_out), 64'd1);
            check($sformatf("f%0d i%0d data", f, i), {o_data_real, o_data_imag}, {e, 0 - e});
            check($sformatf("f%0d i%0d index", f, i), 64'(o_index), 64'(i));
            check($sformatf("f%0d i%0d last", f, i), 64'(o_last), 64'(i == N - 1));
            if (bp && i == 100) begin
                i_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check($sformatf("hold%0d valid", s), 64'(o_valid_out), 64'd1);
                    check($sformatf("hold%0d data", s), 64'(o_data_real), 64'(e));
                    check($sformatf("hold%0d index", s), 64'(o_index), 64'd100);
                end
                i_ready = 1'b1;
            end
            tick();
        end
        check($sformatf("f%0d end valid", f), 64'(o_valid_out), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " valid"}, 64'(o_valid_out), 64'd0);
        check({tag, " data"}, {o_data_real, o_data_imag}, 64'd0);
        check({tag, " index"}, 64'(o_index), 64'd0);
        check({tag, " last"}, 64'(o_last), 64'd0);
        check({tag, " ovf"}, 64'(o_overflow), 64'd0);
    endtask

    initial begin
        int n;
        i_reset = 1'b0;
        i_ready = 1'b0;
        i_valid_in = 1'b0;
        {i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag} = '0;

        // Reset held with inputs toggling randomly.
        for (int c = 0; c < 10; c++) begin
            i_valid_in    = 1'($urandom);
            i_ready       = 1'($urandom);
            i_data_a_real = $urandom;
            i_data_a_imag = $urandom;
            i_data_b_real = $urandom;
            i_data_b_imag = $urandom;
            tick();
            check_reset_outputs($sformatf("rst%0d", c));
        end
        i_valid_in = 1'b0;
        i_ready    = 1'b1;
        i_reset    = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            check($sformatf("idle%0d valid", c), 64'(o_valid_out), 64'd0);
        end

        // Frame 0 with a 3-edge latency check, then full stream with backpressure at index 100.
        send_pairs(0, 0, N / 2);
        check("lat edge1", 64'(o_valid_out), 64'd0);
        tick();
        check("lat edge2", 64'(o_valid_out), 64'd0);
        tick();
        check("lat edge3", 64'(o_valid_out), 64'd0);
        tick();
        check("lat valid", 64'(o_valid_out), 64'd1);
        stream_frame(0, 1'b1);
        check("no ovf", 64'(o_overflow), 64'd0);

        // Overflow: three frames with the reader stalled; the third is dropped.
        i_ready = 1'b0;
        send_pairs(1, 0, N / 2);
        send_pairs(2, 0, N / 2);
        check("ovf before f3", 64'(o_overflow), 64'd0);
        send_pairs(3, 0, 1);
        check("ovf on f3 pair0", 64'(o_overflow), 64'd1);
        send_pairs(3, 1, N / 2);
        i_ready = 1'b1;
        stream_frame(1, 1'b0);
        stream_frame(2, 1'b0);
        for (int c = 0; c < 30; c++) begin
            tick();
            check($sformatf("f3 absent%0d", c), 64'(o_valid_out), 64'd0);
        end
        check("ovf sticky", 64'(o_overflow), 64'd1);

        // Reset in the middle of a streaming frame, then a fresh frame.
        send_pairs(4, 0, N / 2);
        wait_valid("f4 start");
        n = 0;
        while (o_index != LOG2N'(300) && n < 400) begin
            tick();
            n++;
        end
        check("f4 reach 300", 64'(o_index), 64'd300);
        i_reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        i_reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("post rst%0d valid", c), 64'(o_valid_out), 64'd0);
        end
        send_pairs(5, 0, N / 2);
        stream_frame(5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
